// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: sync, clock filter, deframer, E0/F0 prefix folding
module ps2_kbd_rx #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 16383
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       byte_strobe,
  output logic [7:0] byte_data,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [3:0]  FILT_LAST = 4'(FILTER - 1);
  localparam logic [13:0] TO_LIMIT  = 14'(TIMEOUT);

  logic        clk_s1, clk_s2, dat_s1, dat_s2;
  logic        clk_f;
  logic [3:0]  flt_cnt;
  logic        fall;

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par, par_n;
  logic [13:0] to_cnt, to_cnt_n;
  logic        frame_ok, frame_bad;

  logic        ext_pend, rel_pend;
  logic        is_e0, is_f0, is_e1;

  // Two-flop synchronizers for both PS/2 lines; idle level is high.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_kbd_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_kbd_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock deglitch: clk_f follows only after FILTER consecutive differing samples; fall marks the 1->0 change.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_f   <= 1'b1;
      flt_cnt <= 4'd0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != clk_f) begin
        if (flt_cnt == FILT_LAST) begin
          clk_f   <= clk_s2;
          flt_cnt <= 4'd0;
          fall    <= clk_f & ~clk_s2;
        end else begin
          flt_cnt <= flt_cnt + 4'd1;
        end
      end else begin
        flt_cnt <= 4'd0;
      end
    end
  end

  // Deframer state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      par     <= 1'b0;
      to_cnt  <= 14'd0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      to_cnt  <= to_cnt_n;
    end
  end

  // Deframer next state; par accumulates data and parity bits so a good frame ends with par = 1.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    to_cnt_n  = to_cnt + 14'd1;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (state == IDLE) begin
      to_cnt_n = 14'd0;
      if (fall && !dat_s2) begin
        state_n   = DATA;
        bit_cnt_n = 3'd0;
        par_n     = 1'b0;
      end
    end else if (to_cnt == TO_LIMIT) begin
      state_n   = IDLE;
      to_cnt_n  = 14'd0;
      frame_bad = 1'b1;
    end else if (fall) begin
      to_cnt_n = 14'd0;
      case (state)
        DATA: begin
          shift_n   = {dat_s2, shift[7:1]};
          par_n     = par ^ dat_s2;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = par ^ dat_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat_s2 && par) frame_ok = 1'b1;
          else               frame_bad = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Prefix byte decode of the byte completing this cycle.
  always_comb begin
    is_e0 = (shift == 8'hE0);
    is_f0 = (shift == 8'hF0);
    is_e1 = (shift == 8'hE1);
  end

  // Registered byte/key outputs and pending prefix flags; flags are untouched by bad frames.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      byte_strobe  <= 1'b0;
      byte_data    <= 8'h00;
      key_strobe   <= 1'b0;
      key_code     <= 8'h00;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      frame_err    <= 1'b0;
      ext_pend     <= 1'b0;
      rel_pend     <= 1'b0;
    end else begin
      byte_strobe <= frame_ok;
      frame_err   <= frame_bad;
      key_strobe  <= 1'b0;
      if (frame_ok) begin
        byte_data <= shift;
        if (is_e0) begin
          ext_pend <= 1'b1;
        end else if (is_f0) begin
          rel_pend <= 1'b1;
        end else if (is_e1) begin
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end else begin
          key_strobe   <= 1'b1;
          key_code     <= shift;
          key_pressed  <= ~rel_pend;
          key_extended <= ext_pend;
          ext_pend     <= 1'b0;
          rel_pend     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - randomized self-checking bench for ps2_kbd_rx against a prefix/event model
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 16383;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       byte_strobe, key_strobe, key_pressed, key_extended, frame_err;
  logic [7:0] byte_data, key_code;

  ps2_kbd_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk),
    .reset        (rst),
    .ps2_kbd_clk  (ps2_clk),
    .ps2_kbd_data (ps2_dat),
    .byte_strobe  (byte_strobe),
    .byte_data    (byte_data),
    .key_strobe   (key_strobe),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected-side model state
  logic [7:0] exp_bytes[$];
  logic [9:0] exp_keys[$];
  int         exp_errs = 0;
  bit         m_ext = 0, m_rel = 0;
  logic [7:0] last_byte = 8'h00;
  logic [9:0] last_key = 10'h000;

  // observed-side capture
  logic [7:0] obs_bytes[$];
  logic [9:0] obs_keys[$];
  int         obs_errs = 0;
  int         obs_both = 0;

  always @(posedge clk) begin
    #1;
    if (byte_strobe) obs_bytes.push_back(byte_data);
    if (key_strobe)  obs_keys.push_back({key_code, key_pressed, key_extended});
    if (frame_err)   obs_errs++;
    if (byte_strobe && frame_err) obs_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model: a good byte applies the prefix rules
  task automatic model_good(input logic [7:0] b);
    exp_bytes.push_back(b);
    last_byte = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else if (b == 8'hE1) begin m_ext = 0; m_rel = 0; end
    else begin
      last_key = {b, ~m_rel, m_ext};
      exp_keys.push_back(last_key);
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  task automatic ps2_bit(input logic b, input int hp, input bit glitch);
    ps2_dat = b;
    clks(hp / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      clks(2);
      ps2_clk = 1'b1;
    end
    clks(hp - hp / 2);
    ps2_clk = 1'b0;
    clks(hp);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit 0; nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input int kind, input int nbits, input bit glitch);
    logic [10:0] fr;
    int hp;
    hp = $urandom_range(12, 30);
    fr[0] = 1'b0;
    fr[8:1] = b;
    fr[9] = ~(^b) ^ (kind == 1);
    fr[10] = (kind == 2) ? 1'b0 : 1'b1;
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], hp, glitch && (i % 3 == 1));
    ps2_dat = 1'b1;
    if (nbits == 11) begin
      if (kind == 0) model_good(b);
      else exp_errs++;
    end
  endtask

  task automatic check_step(input string tag);
    clks(12);
    chk({tag, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
    for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++)
      chk({tag, "_byte"}, obs_bytes[i], exp_bytes[i]);
    chk({tag, "_nkeys"}, obs_keys.size(), exp_keys.size());
    for (int i = 0; i < obs_keys.size() && i < exp_keys.size(); i++)
      chk({tag, "_key"}, obs_keys[i], exp_keys[i]);
    chk({tag, "_errs"}, obs_errs, exp_errs);
    chk({tag, "_both"}, obs_both, 0);
    chk({tag, "_byte_hold"}, byte_data, last_byte);
    chk({tag, "_key_hold"}, {key_code, key_pressed, key_extended}, last_key);
    obs_bytes.delete(); exp_bytes.delete();
    obs_keys.delete();  exp_keys.delete();
    obs_errs = 0; exp_errs = 0; obs_both = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_bs"}, byte_strobe, 0);
    chk({tag, "_bd"}, byte_data, 0);
    chk({tag, "_ks"}, key_strobe, 0);
    chk({tag, "_kc"}, key_code, 0);
    chk({tag, "_kp"}, key_pressed, 0);
    chk({tag, "_ke"}, key_extended, 0);
    chk({tag, "_fe"}, frame_err, 0);
  endtask

  initial begin
    clks(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    clks(10);

    send_frame(8'h1C, 0, 11, 0);
    check_step("make_1c");

    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    send_frame(8'hE0, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h75, 0, 11, 0);
    check_step("prefix");

    send_frame(8'h1C, 1, 11, 0);
    send_frame(8'h32, 0, 11, 0);
    check_step("parity");

    send_frame(8'h44, 2, 11, 0);
    check_step("stop0");

    send_frame(8'h3B, 0, 6, 0);
    clks(TIMEOUT + 10);
    exp_errs++;
    check_step("timeout");
    send_frame(8'h29, 0, 11, 0);
    check_step("after_to");

    ps2_clk = 1'b0; clks(2); ps2_clk = 1'b1; clks(10);
    send_frame(8'h1C, 0, 11, 1);
    ps2_clk = 1'b0; clks(2); ps2_clk = 1'b1; clks(10);
    check_step("glitch");

    send_frame(8'hE0, 0, 11, 0);
    send_frame(8'h5A, 0, 5, 0);
    rst = 1'b1;
    clks(3);
    check_zero_outputs("midreset");
    m_ext = 0; m_rel = 0; last_byte = 8'h00; last_key = 10'h000;
    exp_bytes.delete(); exp_keys.delete();
    obs_bytes.delete(); obs_keys.delete();
    rst = 1'b0;
    clks(10);
    check_step("midreset_quiet");
    send_frame(8'h5A, 0, 11, 0);
    check_step("after_reset");

    for (int n = 0; n < 24; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2) b = 8'hE1;
      send_frame(b, (r == 3) ? 1 : (r == 4) ? 2 : 0, 11, $urandom_range(0, 3) == 0);
      if (n % 6 == 5) check_step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Receives the serial PS/2 keyboard stream emitted by the MiST I/O bridge (`ps2_kbd_clk` / `ps2_kbd_data`, 12–16 kHz, clock idle high) and converts it into parallel scan-code events in the core clock domain. It deframes each 11-bit PS/2 frame: start bit, 8 data bits LSB first, odd parity, stop bit. It checks parity and framing, and folds the `E0`/`F0` prefixes into extended/release flags. The Spectrum keyboard matrix consumes its output.

## Interface
Parameters:
- `FILTER`, 4: number of consecutive equal synchronized samples required before the filtered PS/2 clock changes level (range 2..15).
- `TIMEOUT`, 16383: core clocks without a falling edge after which a partial frame is discarded (14-bit counter).

Ports:
- `clk_sys` in 1: core clock (28 MHz nominal); all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ps2_kbd_clk` in 1: PS/2 clock, asynchronous to `clk_sys`, idle high.
- `ps2_kbd_data` in 1: PS/2 data, asynchronous to `clk_sys`.
- `byte_strobe` out 1: one-cycle pulse; a valid frame was received, including prefix bytes.
- `byte_data` out 8: raw received byte; held until the next valid frame.
- `key_strobe` out 1: one-cycle pulse; a complete key event is ready.
- `key_code` out 8: scan code of the event; held until the next event.
- `key_pressed` out 1: 1 = make, 0 = break (an `F0` was seen).
- `key_extended` out 1: 1 = an `E0` prefix was seen.
- `frame_err` out 1: one-cycle pulse on parity error, bad stop bit, or timeout.

## Operation
- Input conditioning:
  - Each input passes through a 2-FF synchronizer.
  - `clk_f` (reset 1) takes the new level only after `FILTER` consecutive synchronized samples differ from its current level.
  - `fall` is a registered pulse, true for one cycle when `clk_f` goes 1→0.
  - On `fall`, the synchronized data bit is sampled.
- Deframer FSM. States IDLE, DATA, PARITY, STOP; `bit_cnt[2:0]`, `shift[7:0]`, `par`.
  - IDLE, `fall` with data=0: go to DATA; `bit_cnt`=0, `par`=0.
  - IDLE, `fall` with data=1: stay in IDLE (treated as a glitch, no error).
  - DATA, `fall`: shift the bit in at MSB (`shift` <= {d, shift[7:1]}); `par` ^= d. After the 8th bit go to PARITY.
  - PARITY, `fall`: capture the parity bit; go to STOP.
  - STOP, `fall`: go to IDLE.
    - Stop bit = 1 and (`par` ^ parity bit) = 1 (odd parity): the frame is valid.
    - Otherwise pulse `frame_err` and drop the byte.
  - Timeout: a 14-bit idle counter is cleared on every `fall` and in IDLE.
    - In any non-IDLE state, when the counter reaches `TIMEOUT`, go to IDLE and pulse `frame_err`.
    - No byte is emitted.
- Prefix logic, run on each valid byte (`byte_strobe`):
  - `E0`: set the pending extended flag; no key event.
  - `F0`: set the pending release flag; no key event.
  - `E1`: clear both pending flags; no key event (Pause sequence; its trailing bytes decode as ordinary events).
  - Any other value:
    - Pulse `key_strobe`, with `key_code` = byte, `key_pressed` = !release, `key_extended` = ext.
    - Clear both pending flags.
- Pending flags survive `frame_err` (a corrupted byte does not reset the prefix context).

## Timing
- Reset values:
  - `byte_strobe`, `key_strobe`, `frame_err`, `key_pressed`, `key_extended` = 0.
  - `byte_data`, `key_code` = 0x00.
  - FSM in IDLE, pending flags 0, `clk_f` = 1.
- Input-to-`fall` latency: 2 sync cycles + `FILTER` cycles + 1 edge-register cycle after the pin edge.
- Strobe timing relative to the cycle in which `fall` of the stop bit is high:
  - `byte_strobe`, `byte_data`, and `frame_err` update at the next clock edge.
  - `key_strobe` and the key outputs update in the same cycle as `byte_strobe` (combinational prefix decode registered together).
- `byte_strobe` and `frame_err` are never asserted in the same cycle.
- Pulses shorter than `FILTER` clocks on `ps2_kbd_clk` produce no `fall`.
- Reset asserted mid-frame: the frame is abandoned immediately with no strobe or error pulse. After release, the next start bit is decoded normally.
- A frame arriving immediately after a timeout is decoded normally. The timeout check has priority over a `fall` in the same cycle.

## Test plan
- Send frame 0x1C with parity 0 -> one `byte_strobe` with `byte_data`=0x1C, and `key_strobe` with `key_code`=0x1C, `key_pressed`=1, `key_extended`=0.
- Send `F0`,`1C` then `E0`,`F0`,`75` -> exactly two `key_strobe`: (0x1C, pressed 0, ext 0), then (0x75, pressed 0, ext 1); `byte_strobe` count = 5.
- Send 0x1C with the parity bit flipped, then a valid 0x32 -> one `frame_err`, no event for 0x1C, then a `key_strobe` for 0x32.
- Send stop bit 0 -> `frame_err`, no `byte_strobe`. Stop clocking after 5 data bits, wait `TIMEOUT`+10 clocks -> one `frame_err`, FSM in IDLE; a following valid 0x29 decodes correctly.
- Inject 2-cycle low glitches on `ps2_kbd_clk` (`FILTER`=4) between and within frames -> no extra bits; 0x1C still decoded correctly.
- Assert `reset` after 4 data bits of a frame -> all outputs 0 and no strobe; a full 0x5A frame after release yields `key_code`=0x5A.
